pipe_stage_elastic_reg: RTL and testbench

//  Parametrised elastic successor to the fixed ID/EX-style stage registers. Carries one control

---
 rtl/pipe_stage_elastic_reg.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_elastic_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic_reg.sv
// Elastic pipeline stage register: one ctrl + one data bundle per entry, 2-entry skid, flush.
// Optional perf counters (stall_cnt/bubble_cnt) compiled in with `define PIPE_STAGE_PERF_EN.
module pipe_stage_elastic_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 32
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_ent;
  logic   accept, drain;

  // Handshake outputs come straight from state flops: no in->out or out_ready->in_ready path.
  always_comb begin
    in_ready  = (state_q != S_TWO);
    out_valid = (state_q != S_EMPTY);
    out_ctrl  = main_q.ctrl & {CTRL_W{out_valid}};
    out_data  = main_q.data;
    case (state_q)
      S_ONE:   occupancy = 2'd1;
      S_TWO:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    in_ent.ctrl = in_ctrl;
    in_ent.data = in_data;
    accept      = in_valid & in_ready;
    drain       = out_valid & out_ready;
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = in_ent;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          main_d = in_ent;
        end else if (accept) begin
          skid_d  = in_ent;
          state_d = S_TWO;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush wins: drop everything, zero ctrl, leave data regs untouched.
    if (flush) begin
      state_d     = S_EMPTY;
      main_d.ctrl = '0;
      main_d.data = main_q.data;
      skid_d.ctrl = '0;
      skid_d.data = skid_q.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush does not touch them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!out_valid && !(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic_reg.sv
// Scoreboard bench for pipe_stage_elastic_reg: directed scenarios then randomized traffic.
module tb_pipe_stage_elastic_reg;
  localparam int CTRL_W = 9;
  localparam int DATA_W = 32;
  localparam int TB_CNT_W = 4;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [TB_CNT_W-1:0] stall_cnt, bubble_cnt;
  int exp_stall = 0, exp_bubble = 0;
`endif

  int checks = 0, failures = 0, drains = 0;
  logic last_taken = 1'b0;
  ent_t exp_q[$];

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_elastic_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(TB_CNT_W)) dut (
`else
  pipe_stage_elastic_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
`endif
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Expected-entry recorder: runs after the monitor has popped for this cycle.
  always @(negedge clk) begin
    #1;
    last_taken = 1'b0;
    if (rst) exp_q.delete();
    else begin
      last_taken = in_valid && in_ready;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  // Monitor: compares DUT outputs against the held-entry queue and pops on every drain.
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
      if (out_valid && out_ready) begin
        drains++;
        if (exp_q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
        end
      end
    end
`ifdef PIPE_STAGE_PERF_EN
    if (rst) begin
      exp_stall = 0;
      exp_bubble = 0;
    end
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubble));
    if (!rst) begin
      if (out_valid && !out_ready && exp_stall < (1 << TB_CNT_W) - 1) exp_stall++;
      if (!out_valid && exp_bubble < (1 << TB_CNT_W) - 1) exp_bubble++;
    end
`endif
  end

  task automatic drive(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl);
    @(posedge clk); #1;
    in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, ordy, 1'b0);
  endtask

  // Hold one entry on the input until the stage shows in_ready, bounded.
  task automatic push_hold(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input logic ordy);
    int n = 0;
    logic done = 1'b0;
    while (!done && n < 16) begin
      drive(1'b1, c, d, ordy, 1'b0);
      @(negedge clk); #2;
      done = in_ready;
      n++;
    end
    if (!done) chk("push_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int snap;
    int bias;
    logic [CTRL_W-1:0] rc;
    logic [DATA_W-1:0] rd;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Stream 0..7 at full rate: eight drains on eight consecutive cycles.
    drive(1'b1, 9'h1, 32'd0, 1'b1, 1'b0);
    snap = drains;
    for (int i = 1; i < 8; i++) drive(1'b1, CTRL_W'(i + 1), DATA_W'(i), 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk); #2;
    chk("stream_drains", 64'(drains - snap), 64'd8);

    // A,B,C under stall: skid fills, C held off, then released in order.
    drive(1'b1, 9'h0a1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 9'h0b2, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 9'h0c3, 32'hC, 1'b0, 1'b0);
    @(negedge clk); #2;
    chk("abc_occ2", 64'(occupancy), 64'd2);
    chk("abc_in_ready0", 64'(in_ready), 64'd0);
    drive(1'b1, 9'h0c3, 32'hC, 1'b0, 1'b0);
    push_hold(9'h0c3, 32'hC, 1'b1);
    idle(1'b1);
    repeat (3) idle(1'b1);

    // Flush with both entries held and a new input presented.
    drive(1'b1, 9'h111, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 9'h122, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 9'h133, 32'h33, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk); #2;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    // Flush in ONE with an accept in the same cycle: that entry is dropped too.
    drive(1'b1, 9'h144, 32'h44, 1'b0, 1'b0);
    drive(1'b1, 9'h155, 32'h55, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk); #2;
    chk("flush_one_occ", 64'(occupancy), 64'd0);

    // Reset mid-stream while full.
    drive(1'b1, 9'h166, 32'h66, 1'b0, 1'b0);
    drive(1'b1, 9'h177, 32'h77, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_imm_valid", 64'(out_valid), 64'd0);
    chk("rst_imm_occ", 64'(occupancy), 64'd0);
    chk("rst_imm_ready", 64'(in_ready), 64'd1);
    chk("rst_imm_ctrl", 64'(out_ctrl), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); #2;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

`ifdef PIPE_STAGE_PERF_EN
    // Long stall saturates stall_cnt; flush leaves it alone.
    drive(1'b1, 9'h1ff, 32'h99, 1'b0, 1'b0);
    repeat (20) idle(1'b0);
    @(negedge clk); #2;
    chk("stall_sat", 64'(stall_cnt), 64'd15);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk); #2;
    chk("stall_after_flush", 64'(stall_cnt), 64'd15);
`endif

    // Randomized traffic with varying back-pressure and occasional flush.
    for (int i = 0; i < 10000; i++) begin
      bias = (i / 1000) % 4;
      if (in_valid && !last_taken) begin
        rc = in_ctrl; rd = in_data;
        drive(1'b1, rc, rd, logic'($urandom_range(3, 0) >= bias), logic'($urandom_range(40, 0) == 0));
      end else begin
        rc = CTRL_W'($urandom()) | CTRL_W'(1);
        rd = $urandom();
        drive(logic'($urandom_range(2, 0) != 0), rc, rd,
              logic'($urandom_range(3, 0) >= bias), logic'($urandom_range(40, 0) == 0));
      end
    end
    repeat (4) idle(1'b1);
    @(negedge clk); #2;
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
